// File: rtl/ctrl_encode_pkg.sv
// Shared control encodings for the data-memory path: access types, store-buffer
// depth default and the alignment rule used by both store and load sides.
package ctrl_encode;

    typedef enum logic [2:0] {
        DM_WORD  = 3'b000,
        DM_HALF  = 3'b001,
        DM_HALFU = 3'b010,
        DM_BYTE  = 3'b011,
        DM_BYTEU = 3'b100
    } dm_type_e;

    localparam int unsigned DM_SB_DEPTH = 4;

    // Unlisted encodings behave as word accesses, so they carry the word rule.
    function automatic logic dm_misaligned(input logic [2:0] t, input logic [1:0] off);
        logic res;
        case (t)
            DM_HALF, DM_HALFU: res = off[0];
            DM_BYTE, DM_BYTEU: res = 1'b0;
            default:           res = (off != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for stores (enables + replication) and lane selection
// with sign/zero extension for loads.
module dm_lane_align
    import ctrl_encode::*;
(
    input  logic [2:0]  dmtype_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_lanes_o,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [15:0] sel_h;
    logic [7:0]  sel_b;

    assign sel_h = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    assign sel_b = 8'(ld_word_i >> {off_i, 3'b000});

    always_comb begin
        st_be_o    = 4'b1111;
        st_lanes_o = st_data_i;
        ld_data_o  = ld_word_i;
        case (dmtype_i)
            DM_HALF, DM_HALFU: begin
                st_be_o    = 4'b0011 << off_i;
                st_lanes_o = {2{st_data_i[15:0]}};
                ld_data_o  = (dmtype_i == DM_HALF) ? {{16{sel_h[15]}}, sel_h}
                                                   : {16'b0, sel_h};
            end
            DM_BYTE, DM_BYTEU: begin
                st_be_o    = 4'b0001 << off_i;
                st_lanes_o = {4{st_data_i[7:0]}};
                ld_data_o  = (dmtype_i == DM_BYTE) ? {{24{sel_b[7]}}, sel_b}
                                                   : {24'b0, sel_b};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dm_store_buffer.sv
// Store buffer between the CPU memory stage and backing memory: FIFO of
// aligned stores drained by a req/gnt handshake, with store-to-load merge.
module dm_store_buffer
    import ctrl_encode::*;
#(
    parameter int unsigned DEPTH = DM_SB_DEPTH,
    parameter int unsigned AW    = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     mem_we,
    input  logic                     mem_re,
    input  logic [AW-1:0]            addr,
    input  logic [31:0]              wdata,
    input  logic [2:0]               dmtype,
    output logic [31:0]              rdata,
    output logic                     stall_o,
    output logic                     misalign,
    output logic                     wr_req,
    input  logic                     wr_gnt,
    output logic [AW-3:0]            wr_addr,
    output logic [31:0]              wr_data,
    output logic [3:0]               wr_be,
    output logic [AW-3:0]            rd_addr,
    input  logic [31:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-3:0]   ent_addr_q [DEPTH];
    logic [31:0]     ent_data_q [DEPTH];
    logic [3:0]      ent_be_q   [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic            mis, full, push, pop;
    logic [3:0]      st_be;
    logic [31:0]     st_lanes, merged, ld_data;

    assign mis  = dm_misaligned(dmtype, addr[1:0]);
    assign full = (count_q == CW'(DEPTH));
    assign pop  = wr_req & wr_gnt;
    assign push = mem_we & ~mis & (~full | pop);

    assign wr_req   = (count_q != '0);
    assign wr_addr  = ent_addr_q[head_q];
    assign wr_data  = ent_data_q[head_q];
    assign wr_be    = ent_be_q[head_q];
    assign count    = count_q;
    assign rd_addr  = addr[AW-1:2];
    assign stall_o  = mem_we & full & ~pop;
    assign misalign = rstn & (mem_we | mem_re) & mis;
    assign rdata    = (mem_re & ~mem_we & ~mis) ? ld_data : '0;

    dm_lane_align u_lane (
        .dmtype_i   (dmtype),
        .off_i      (addr[1:0]),
        .st_data_i  (wdata),
        .st_be_o    (st_be),
        .st_lanes_o (st_lanes),
        .ld_word_i  (merged),
        .ld_data_o  (ld_data)
    );

    // Pop is applied before push so a full-buffer push into the slot being
    // vacated leaves that slot valid.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        count_d = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[tail_q] <= addr[AW-1:2];
            ent_data_q[tail_q] <= st_lanes;
            ent_be_q[tail_q]   <= st_be;
        end
    end

    // Walk entries oldest to newest so younger stores overwrite older bytes.
    always_comb begin
        logic [PW-1:0] idx;
        merged = rd_data;
        idx    = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && valid_q[idx] && (ent_addr_q[idx] == addr[AW-1:2])) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (ent_be_q[idx][b]) merged[8*b +: 8] = ent_data_q[idx][8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_dm_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_we = 1'b0, mem_re = 1'b0, wr_gnt = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rd_data = '0;
    logic [2:0]  dmtype = '0;
    logic [31:0] rdata, wr_data;
    logic        stall_o, misalign, wr_req;
    logic [29:0] wr_addr, rd_addr;
    logic [3:0]  wr_be;
    logic [2:0]  count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic [29:0] wa;
        logic [3:0]  be;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    dm_store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstn(rstn), .mem_we(mem_we), .mem_re(mem_re), .addr(addr),
        .wdata(wdata), .dmtype(dmtype), .rdata(rdata), .stall_o(stall_o),
        .misalign(misalign), .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rd_data),
        .count(count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_mis(input logic [2:0] t, input logic [1:0] off);
        if (t == 3'd1 || t == 3'd2) return off[0];
        if (t == 3'd3 || t == 3'd4) return 1'b0;
        return off != 2'd0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [1:0] off);
        if (t == 3'd1 || t == 3'd2) return 4'(3 << off);
        if (t == 3'd3 || t == 3'd4) return 4'(1 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_sdata(input logic [2:0] t, input logic [31:0] d);
        if (t == 3'd1 || t == 3'd2) return {d[15:0], d[15:0]};
        if (t == 3'd3 || t == 3'd4) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_rdata();
        logic [31:0] w;
        int unsigned off, v;
        if (!mem_re || mem_we || m_mis(dmtype, addr[1:0])) return 32'h0;
        w = rd_data;
        foreach (q[i]) begin
            if (q[i].wa == addr[31:2]) begin
                for (int b = 0; b < 4; b++)
                    if (q[i].be[b]) w[8*b +: 8] = q[i].d[8*b +: 8];
            end
        end
        off = addr[1:0];
        case (dmtype)
            3'd1: begin v = (w >> (8 * off)) & 32'hFFFF; return (v >= 32'h8000) ? v - 32'h10000 : v; end
            3'd2: return (w >> (8 * off)) & 32'hFFFF;
            3'd3: begin v = (w >> (8 * off)) & 32'hFF; return (v >= 32'h80) ? v - 32'h100 : v; end
            3'd4: return (w >> (8 * off)) & 32'hFF;
            default: return w;
        endcase
    endfunction

    task automatic check_all();
        int unsigned n;
        logic full, pop;
        n    = q.size();
        pop  = (n > 0) && wr_gnt;
        full = (n == DEPTH);
        check_eq("count", 32'(count), n);
        check_eq("wr_req", 32'(wr_req), 32'(n > 0));
        check_eq("rd_addr", 32'(rd_addr), 32'(addr[31:2]));
        check_eq("stall_o", 32'(stall_o), 32'(mem_we && full && !pop));
        check_eq("misalign", 32'(misalign), 32'((mem_we || mem_re) && m_mis(dmtype, addr[1:0])));
        check_eq("rdata", rdata, m_rdata());
        if (n > 0) begin
            check_eq("wr_addr", 32'(wr_addr), 32'(q[0].wa));
            check_eq("wr_data", wr_data, q[0].d);
            check_eq("wr_be", 32'(wr_be), 32'(q[0].be));
        end
    endtask

    // Called at a falling edge: apply inputs, then sample combinational outputs.
    task automatic drive(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] t,
                         input logic gnt, input logic [31:0] rd);
        mem_we = we; mem_re = re; addr = a; wdata = wd; dmtype = t;
        wr_gnt = gnt; rd_data = rd;
        #1;
        check_all();
    endtask

    task automatic tick();
        logic pop, acc;
        @(posedge clk);
        if (!rstn) begin
            q.delete();
        end else begin
            pop = (q.size() > 0) && wr_gnt;
            acc = mem_we && !m_mis(dmtype, addr[1:0]) && ((q.size() < DEPTH) || pop);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{wa: addr[31:2], be: m_be(dmtype, addr[1:0]),
                                   d: m_sdata(dmtype, wdata)});
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 16 && q.size() > 0; k++) begin
            drive(0, 0, 32'h0, 32'h0, 3'd0, 1, 32'h0);
            tick();
        end
        drive(0, 0, 32'h0, 32'h0, 3'd0, 0, 32'h0);
        check_eq("drained_count", 32'(count), 32'h0);
    endtask

    initial begin
        // Reset state, with a misaligned store presented to confirm gating.
        mem_we = 1; addr = 32'h102; dmtype = 3'd0;
        #2;
        check_eq("rst_count", 32'(count), 32'h0);
        check_eq("rst_wr_req", 32'(wr_req), 32'h0);
        check_eq("rst_stall", 32'(stall_o), 32'h0);
        check_eq("rst_misalign", 32'(misalign), 32'h0);
        @(negedge clk);
        rstn = 1;

        // sb 0x103 then lb 0x103
        drive(1, 0, 32'h103, 32'hAB, 3'd3, 0, 32'h0);
        tick();
        drive(0, 1, 32'h103, 32'h0, 3'd3, 0, 32'h11223344);
        check_eq("sb_lb_rdata", rdata, 32'hFFFFFFAB);
        check_eq("sb_count", 32'(count), 32'h1);
        check_eq("sb_wr_be", 32'(wr_be), 32'h8);
        check_eq("sb_wr_data", wr_data, 32'hABABABAB);
        tick();
        drain();

        // sh 0x102 then lhu / lh
        drive(1, 0, 32'h102, 32'h8001, 3'd1, 0, 32'h0);
        tick();
        drive(0, 1, 32'h102, 32'h0, 3'd2, 0, 32'h0);
        check_eq("lhu_rdata", rdata, 32'h00008001);
        tick();
        drain();
        drive(1, 0, 32'h102, 32'h8001, 3'd1, 0, 32'h0);
        tick();
        drive(0, 1, 32'h102, 32'h0, 3'd1, 0, 32'h0);
        check_eq("lh_rdata", rdata, 32'hFFFF8001);
        tick();
        drain();

        // Fill to DEPTH, stall the 5th, accept it when wr_gnt rises
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h200 + 32'(4 * i), 32'hC000_0000 + 32'(i), 3'd0, 0, 32'h0);
            tick();
        end
        drive(1, 0, 32'h210, 32'hC0000004, 3'd0, 0, 32'h0);
        check_eq("full_count", 32'(count), 32'h4);
        check_eq("full_stall", 32'(stall_o), 32'h1);
        tick();
        drive(1, 0, 32'h210, 32'hC0000004, 3'd0, 1, 32'h0);
        check_eq("gnt_stall", 32'(stall_o), 32'h0);
        tick();
        drive(0, 0, 32'h0, 32'h0, 3'd0, 0, 32'h0);
        check_eq("gnt_count", 32'(count), 32'h4);
        check_eq("gnt_tail_addr", 32'(wr_addr), 32'h81);
        drain();

        // Newest store wins in the merge
        drive(1, 0, 32'h10, 32'h11111111, 3'd0, 0, 32'h0);
        tick();
        drive(1, 0, 32'h10, 32'h22, 3'd3, 0, 32'h0);
        tick();
        drive(0, 1, 32'h10, 32'h0, 3'd0, 0, 32'hDEADBEEF);
        check_eq("merge_rdata", rdata, 32'h11111122);
        tick();
        drain();

        // Misaligned word store
        drive(1, 0, 32'h102, 32'h12345678, 3'd0, 0, 32'h0);
        check_eq("mis_pulse", 32'(misalign), 32'h1);
        tick();
        drive(0, 0, 32'h0, 32'h0, 3'd0, 0, 32'h0);
        check_eq("mis_pulse_gone", 32'(misalign), 32'h0);
        check_eq("mis_count", 32'(count), 32'h0);
        check_eq("mis_wr_req", 32'(wr_req), 32'h0);
        tick();

        // Asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h300 + 32'(4 * i), 32'(i), 3'd0, 0, 32'h0);
            tick();
        end
        drive(0, 0, 32'h0, 32'h0, 3'd0, 0, 32'h0);
        check_eq("pre_rst_wr_req", 32'(wr_req), 32'h1);
        #2 rstn = 0;
        #1;
        check_eq("async_rst_wr_req", 32'(wr_req), 32'h0);
        check_eq("async_rst_count", 32'(count), 32'h0);
        tick();
        rstn = 1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 32'h0, 3'd0, 1, 32'h0);
            check_eq("post_rst_wr_req", 32'(wr_req), 32'h0);
            tick();
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
                  32'h40 + 32'($urandom_range(0, 31)), $urandom, 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0), $urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dm_store_buffer.md
DM_STORE_BUFFER -- requirements
Module: dm_store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of store-buffer entries; SHALL be a power of two, 2..8.
REQ-002 Parameter AW, default 32, byte-address width of the CPU and memory ports.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
REQ-004 CPU memory-stage ports SHALL be:
- mem_we  in  1  store request this cycle.
- mem_re  in  1  load request this cycle.
- addr  in  AW  byte address.
- wdata  in  32  store data, right-aligned.
- dmtype  in  3  access type.
- rdata  out  32  aligned, extended load data.
- stall_o  out  1  store not accepted; the CPU must hold the memory stage.
- misalign  out  1  one-cycle pulse on a misaligned access.
REQ-005 Backing-memory ports SHALL be:
- wr_req  out  1  drain request.
- wr_gnt  in  1  drain accepted.
- wr_addr  out  AW-2  word address.
- wr_data  out  32  write data.
- wr_be  out  4  byte enables.
- rd_addr  out  AW-2  word address, combinational read.
- rd_data  in  32  read data, returned in the same cycle.
- count  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-006 dmtype encoding SHALL be: word 000, half 001, half-unsigned 010, byte 011, byte-unsigned 100; any other value is treated as word.
REQ-007 Byte enables SHALL be:
- word: 1111.
- half: 0011 << addr[1:0].
- byte: 0001 << addr[1:0].
REQ-008 Store data SHALL be replicated into the addressed lanes: byte into all 4 lanes, half into both halves.
REQ-009 An access SHALL be misaligned when it is a half with addr[0]=1, or a word with addr[1:0]!=0.
REQ-010 A misaligned store SHALL not be pushed, and misaligned SHALL pulse for one cycle.
REQ-011 A misaligned load SHALL return 0 and pulse misalign.
REQ-012 A store SHALL be accepted (pushed at the clock edge) when mem_we=1, it is aligned, and either count<DEPTH or a pop occurs in the same cycle.
REQ-013 stall_o SHALL equal mem_we & (count==DEPTH) & ~(wr_req & wr_gnt), combinationally; a stalled store is not pushed.
REQ-014 The buffer SHALL be a FIFO with head/tail pointers that wrap modulo DEPTH.
REQ-015 count SHALL increment on push only, decrement on pop only, and stay unchanged on a simultaneous push and pop.
REQ-016 wr_req SHALL be high exactly when count>0.
REQ-017 wr_addr, wr_data and wr_be SHALL present the head entry while wr_req is high.
REQ-018 wr_req & wr_gnt at a clock edge SHALL pop the head entry.
REQ-019 A store pushed into an empty buffer SHALL drive wr_req in the next cycle, giving a store-to-drain latency of 1 cycle.
REQ-020 wr_req, once asserted, SHALL remain asserted with stable address, data and enables until it is granted.
REQ-021 rd_addr SHALL equal addr[AW-1:2] combinationally at all times.
REQ-022 Load merge: starting from rd_data, each byte SHALL be overridden by every valid buffer entry whose word address matches and whose be bit is set, applied oldest to newest so the newest store wins.
REQ-023 An entry being popped in the current cycle SHALL still participate in the load merge.
REQ-024 Load extraction SHALL select the addressed byte or half from the merged word, then sign-extend (byte, half) or zero-extend (byte-unsigned, half-unsigned).
REQ-025 The load path SHALL have 0-cycle latency.
REQ-026 rdata SHALL be 0 when mem_re=0.
REQ-027 When mem_we and mem_re are both 1, the access SHALL be treated as a store only, and rdata SHALL be 0.

Reset
REQ-028 While rstn=0, the following SHALL hold:
- count=0, head=tail=0;
- wr_req=0, stall_o=0, misalign=0;
- all entry valid bits cleared.
REQ-029 Assertion of rstn mid-drain SHALL discard all buffered stores without completing a handshake; wr_req SHALL drop asynchronously.
REQ-030 Entry data and enables need not be reset.

Structure
REQ-031 The dmtype encodings and the DEPTH default SHALL live in the shared ctrl_encode package, alongside the existing dm_* definitions.
REQ-032 Lane steering and extension (REQ-007, REQ-008, REQ-024) SHALL be a sub-module, dm_lane_align, reused by the store path and the load path.
REQ-033 The FIFO, merge and handshake logic SHALL stay in dm_store_buffer.

Verification
REQ-034 The bench SHALL cover the following directed scenarios:
- sb addr 0x103, data 0xAB, wr_gnt held 0, then lb addr 0x103 with rd_data=0x11223344 -> rdata=0xFFFFFFAB; count=1; wr_be=1000, wr_data=0xABABABAB.
- sh addr 0x102, data 0x8001, then lhu addr 0x102 with rd_data=0 -> rdata=0x00008001; the same sequence with lh -> rdata=0xFFFF8001.
- 5 sw to 0x200..0x210 with wr_gnt=0 -> count=4; stall_o=1 on the 5th store; the 5th store is accepted in the cycle wr_gnt rises, and count stays 4.
- sw 0x10 data 0x11111111, then sb 0x10 data 0x22, then lw 0x10 -> rdata=0x11111122.
- sw addr 0x102 -> misalign pulse; count unchanged; no wr_req.
- 3 stores buffered, wr_req high, rstn pulsed low mid-cycle -> wr_req=0 and count=0 immediately, and no wr_gnt handshake completes afterwards.
